button_conditioner: RTL



---
 rtl/button_conditioner.sv | 118 +++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Debounce front end for the direction buttons: two-flop synchronizer per raw pin,
// then a per-channel stability FSM producing a clean level plus press/release pulses.
module button_conditioner #(
    parameter int NBTN      = 5,
    parameter int DB_CYCLES = 400000,
    parameter int CNTW      = $clog2(DB_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] raw,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic            any_held
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [NBTN-1:0] s1_q;
    logic [NBTN-1:0] s2_q;

    // raw is asynchronous; only s2_q is allowed to reach the debounce logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_chan
            state_t          state_q;
            logic [CNTW-1:0] cnt_q;
            logic            btn_q;
            logic            dn_q;
            logic            up_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    btn_q   <= 1'b0;
                    dn_q    <= 1'b0;
                    up_q    <= 1'b0;
                end else begin
                    dn_q <= 1'b0;
                    up_q <= 1'b0;
                    case (state_q)
                        IDLE: begin
                            if (s2_q[gi]) begin
                                cnt_q   <= CNT_ONE;
                                state_q <= PRESS_WAIT;
                            end else begin
                                cnt_q <= '0;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!s2_q[gi]) begin
                                cnt_q   <= '0;
                                state_q <= IDLE;
                            end else if (cnt_q == CNT_LAST) begin
                                cnt_q   <= '0;
                                state_q <= HELD;
                                btn_q   <= 1'b1;
                                dn_q    <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        HELD: begin
                            if (!s2_q[gi]) begin
                                cnt_q   <= CNT_ONE;
                                state_q <= RELEASE_WAIT;
                            end
                        end
                        RELEASE_WAIT: begin
                            // A return to high is a bounce: stay pressed and restart.
                            if (s2_q[gi]) begin
                                cnt_q   <= '0;
                                state_q <= HELD;
                            end else if (cnt_q == CNT_LAST) begin
                                cnt_q   <= '0;
                                state_q <= IDLE;
                                btn_q   <= 1'b0;
                                up_q    <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    endcase
                end
            end

            assign btn[gi]    = btn_q;
            assign btn_dn[gi] = dn_q;
            assign btn_up[gi] = up_q;
        end
    endgenerate

    assign any_held = |btn;

endmodule
